// File: rtl/regfile_if.sv
// Register-file bus: write-back result triple plus two decode-stage read ports.
// The master drives the write triple and the read requests; the register file (slave) returns the operand data.
interface regfile_if #(
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [REG_WIDTH-1:0]  wdata;
  logic                  re1;
  logic [ADDR_WIDTH-1:0] raddr1;
  logic [REG_WIDTH-1:0]  rdata1;
  logic                  re2;
  logic [ADDR_WIDTH-1:0] raddr2;
  logic [REG_WIDTH-1:0]  rdata2;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/regfile.sv
// 32x32 integer register file: one synchronous write port, two combinational read ports, r0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to a matching read.
module regfile #(
  parameter int unsigned REG_NUM    = 32,
  parameter int unsigned REG_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst,
  regfile_if.slave  rf
);

  logic [REG_WIDTH-1:0] regs_q [REG_NUM];
  logic [REG_WIDTH-1:0] regs_d [REG_NUM];
  logic [REG_WIDTH-1:0] rdata1_c;
  logic [REG_WIDTH-1:0] rdata2_c;

  // Next-state array: a single write, never to r0.
  always_comb begin
    regs_d = regs_q;
    if (rf.we && (rf.waddr != '0)) begin
      regs_d[rf.waddr] = rf.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(REG_NUM); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read port 1: reset, r0, bypass, enable, in that priority.
  always_comb begin
    rdata1_c = '0;
    if (rst || (rf.raddr1 == '0)) begin
      rdata1_c = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (rf.re1 && rf.we && (rf.raddr1 == rf.waddr)) begin
      rdata1_c = rf.wdata;
`endif
    end else if (rf.re1) begin
      rdata1_c = regs_q[rf.raddr1];
    end
  end

  always_comb begin
    rdata2_c = '0;
    if (rst || (rf.raddr2 == '0)) begin
      rdata2_c = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (rf.re2 && rf.we && (rf.raddr2 == rf.waddr)) begin
      rdata2_c = rf.wdata;
`endif
    end else if (rf.re2) begin
      rdata2_c = regs_q[rf.raddr2];
    end
  end

  assign rf.rdata1 = rdata1_c;
  assign rf.rdata2 = rdata2_c;

endmodule

// File: doc/regfile.md
# regfile

General-purpose register file of the five-stage integer pipeline: 32 registers × 32 bits, one synchronous write port, two read ports. It is the consumer end of the execute-stage result triple (destination address, write enable, write data) once that triple has travelled through the memory and write-back pipeline registers. It is also the source of the two operand values the decode stage hands to execute. Register 0 is hardwired to zero.

## Interface
- Parameters
  - `REG_NUM`, default 32: number of architectural registers.
  - `REG_WIDTH`, default 32: register width in bits.
  - `ADDR_WIDTH`, default 5: register address width; log2(`REG_NUM`).
- Ports
  - Clock and reset: one clock; reset is synchronous and active-high.
    - `clk`, input, 1: pipeline clock; all state updates on the rising edge.
    - `rst`, input, 1: synchronous, active-high reset (`RstEnable` = 1'b1).
  - Write port
    - `we`, input, 1: write enable, from write-back stage `wreg`.
    - `waddr`, input, 5: destination register, from write-back stage `wd`.
    - `wdata`, input, 32: write-back data.
  - Read port 1
    - `re1`, input, 1: read enable, port 1.
    - `raddr1`, input, 5: source register address, port 1.
    - `rdata1`, output, 32: operand 1 to decode; combinational.
  - Read port 2
    - `re2`, input, 1: read enable, port 2.
    - `raddr2`, input, 5: source register address, port 2.
    - `rdata2`, output, 32: operand 2 to decode; combinational.

## Operation
- Storage: array `regs[0..31]` of 32-bit registers.
- Write, on the rising edge of `clk`:
  - If `rst` = 1: all 32 entries are cleared to `ZeroWord`, and any write presented that cycle is discarded.
  - Else if `we` = 1 and `waddr` ≠ 0: `regs[waddr]` ← `wdata`.
  - A write to address 0 is silently dropped; `regs[0]` stays 0 permanently.
- Read, combinational and evaluated independently for each port p ∈ {1, 2}, in this priority order:
  1. `rst` = 1 → `rdatap` = 0.
  2. `raddrp` = 0 → `rdatap` = 0, regardless of `rep` or a pending write to address 0.
  3. Bypass: only when `REGFILE_BYPASS_EN` is defined. If `rep` = 1, `we` = 1 and `raddrp` = `waddr`, then `rdatap` = `wdata`.
  4. `rep` = 1 → `rdatap` = `regs[raddrp]`.
  5. Otherwise (`rep` = 0) → `rdatap` = 0.
- Both ports may read the same address in the same cycle; both return identical values.
- No arithmetic is performed.
- All addresses are the full 5 bits; there are no out-of-range indices.

## Timing
- Write latency: the data is architecturally visible one cycle after `we` is sampled high, i.e. from the next rising edge.
- Read latency: zero cycles; purely combinational from `raddrp`/`rep` (and from `we`/`waddr`/`wdata` when bypass is enabled).
- Read outputs have no reset flop; they read 0 while `rst` is high and reflect the cleared array afterwards.
- Simultaneous write and read of the same non-zero register:
  - Bypass compiled in: the read returns the new `wdata` in the same cycle.
  - Bypass compiled out: the read returns the old value; the new value is returned from the following cycle.
- Reset asserted mid-stream: the write in that cycle is lost and the contents are zero from the next cycle. Reads during the reset cycle return 0.
- Reset deasserted: the first write is accepted on the first edge where `rst` = 0.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
  - Defined: same-cycle write-to-read forwarding inside the register file. This resolves the WB→ID hazard, which is three instructions apart, without external forwarding.
  - Undefined: no internal forwarding. A read of a register being written that cycle returns the stale value, and the hazard must be covered by a stall or by external forwarding.
  - All other behaviour is identical in both builds.

## Test plan
- Reset clear:
  - Stimulus: write 0xDEADBEEF to r5, then assert `rst` for 1 cycle, then read r5 on port 1 with `re1` = 1.
  - Required: 0x00000000 during and after reset.
- Basic write/read:
  - Stimulus: `we` = 1, `waddr` = 3, `wdata` = 0x12345678; next cycle read r3 on both ports.
  - Required: both return 0x12345678.
- r0 protection:
  - Stimulus: write 0xFFFFFFFF to r0; read r0 on port 2 in the same cycle and in the next cycle.
  - Required: 0 in both cycles, in both builds.
- Same-cycle hazard:
  - Stimulus: r7 holds 0x11111111; write 0x22222222 to r7 while reading r7 on port 1.
  - Required: 0x22222222 with `REGFILE_BYPASS_EN`, 0x11111111 without it; 0x22222222 next cycle in both builds.
- Read enable gating:
  - Stimulus: r9 = 0xA5A5A5A5; `re1` = 0, `raddr1` = 9; `re2` = 1, `raddr2` = 9.
  - Required: `rdata1` = 0, `rdata2` = 0xA5A5A5A5. With bypass and a concurrent write of 9, `rdata1` remains 0.
- Reset overrides write:
  - Stimulus: `rst` = 1 and `we` = 1, `waddr` = 4, `wdata` = 0x55 in the same cycle; deassert `rst`; read r4.
  - Required: 0x00000000.
